gift_round_ctrl: RTL
====================

Name: gift_round_ctrl

Overview:
Round sequencer for the one-round-per-cycle GIFT-128 core. It accepts a start request, drives the load/update strobes of the state register and key-schedule register, and generates the 6-bit round constant. For encryption it issues ROUNDS forward rounds. For decryption it first winds the key schedule forward to the last round key, then issues ROUNDS inverse rounds with inverse key updates and an inverse constant LFSR.

Parameters:
ROUNDS, 40, number of cipher rounds (legal range 2..63)
IDX_W, 6, width of round index output

Ports:
inClk  in  1  clock, rising edge
inRstN  in  1  asynchronous active-low reset
inStart  in  1  start request; sampled only in IDLE
inDecrypt  in  1  mode, sampled together with inStart: 1=decrypt, 0=encrypt
inAbort  in  1  abort request (used only with GIFT_CTRL_ABORT_EN)
outReady  out  1  high in IDLE only
outBusy  out  1  high in every state except IDLE
outDone  out  1  one-cycle completion pulse
outStateLoad  out  1  load plaintext/ciphertext into the state register
outKeyLoad  out  1  load external key into the key-schedule register
outKeyFwd  out  1  apply forward key update this cycle
outKeyInv  out  1  apply inverse key update this cycle
outRoundEn  out  1  state register captures round-function output
outRoundInv  out  1  round datapath in inverse mode
outRoundConst  out  6  constant for the current round
outRoundIdx  out  IDX_W  current round number, 1..ROUNDS; 0 outside rounds

Behaviour:
- Reset (async, inRstN=0): state=IDLE, LFSR=6'h00, counter=0, mode=0. All strobes and outDone are 0, outReady=1, outRoundConst=0, outRoundIdx=0.
- All outputs are decoded from registered state, counter and LFSR. There are no combinational paths from inputs to outputs.
- Forward LFSR step: c' = {c[4:0], c[5]^c[4]^1}.
- Inverse LFSR step: c' = {c[0]^c[5]^1, c[5:1]}.
- Constant sequence from 0x01: 01,03,07,0F,1F,3E,...; round 40 constant = 0x1A.
- States: IDLE, LOAD, EXPAND, ROUND, DONE.
- IDLE: on inStart=1 latch inDecrypt and go to LOAD. inStart in any other state is ignored and not queued.
- LOAD (1 cycle):
  - outStateLoad=1, outKeyLoad=1.
  - LFSR <= 0x01, counter <= 1.
  - Next state: encrypt -> ROUND; decrypt -> EXPAND.
- EXPAND (decrypt only, ROUNDS-1 cycles):
  - outKeyFwd=1 and LFSR steps forward each cycle.
  - outRoundEn=0, outRoundIdx=0.
  - Exit to ROUND with LFSR = constant of round ROUNDS and counter = ROUNDS.
- ROUND, encrypt (ROUNDS cycles, counter 1..ROUNDS):
  - outRoundEn=1, outRoundConst=LFSR, outRoundIdx=counter.
  - outKeyFwd=1 except when counter=ROUNDS.
  - LFSR steps forward; counter increments.
- ROUND, decrypt (ROUNDS cycles, counter ROUNDS..1):
  - outRoundEn=1, outRoundInv=1.
  - outKeyInv=1 except when counter=1.
  - LFSR steps inverse; counter decrements.
- Leaving ROUND after the last round goes to DONE.
- DONE (1 cycle): outDone=1, then IDLE. A start is only accepted one cycle after DONE, once back in IDLE.
- Latency with inStart at cycle T0:
  - Encrypt: rounds at T2..T41, outDone at T42.
  - Decrypt: EXPAND at T2..T40, rounds at T41..T80, outDone at T81.
- outKeyFwd and outKeyInv are never high together. outStateLoad and outRoundEn are never high together.
- Reset asserted mid-operation returns to IDLE asynchronously. No outDone is issued for the interrupted operation.

Optional Feature:
GIFT_CTRL_ABORT_EN.
- Defined: inAbort=1 in LOAD, EXPAND or ROUND forces IDLE on the next edge. Counter and LFSR are cleared, no outDone is issued, and all strobes are 0 from that edge. inAbort in IDLE or DONE has no effect.
- Undefined: inAbort is ignored; the port remains present.

Test Plan:
1. Reset, then idle: outReady=1, outBusy=0, all strobes 0, outRoundConst=0x00, outRoundIdx=0.
2. Encrypt, inStart=1 at T0, inDecrypt=0:
   - outStateLoad=outKeyLoad=1 at T1.
   - outRoundConst=0x01,0x03,0x07,... from T2; 0x1A at T41, with outKeyFwd=0 at T41.
   - outDone=1 at T42 only.
3. Decrypt, inStart=1, inDecrypt=1:
   - outKeyFwd high for exactly 39 cycles (T2..T40).
   - T41: outRoundConst=0x1A, outRoundIdx=40, outKeyInv=1.
   - T80: outRoundConst=0x01, outRoundIdx=1, outKeyInv=0.
   - outDone=1 at T81.
4. inStart pulsed at T10 during encryption: no effect, outDone still at T42. A new inStart at T43 produces outKeyLoad at T44.
5. inRstN=0 at T20 of a decryption: outBusy=0 immediately (asynchronous), no outDone, next start behaves as in test 3.
6. With GIFT_CTRL_ABORT_EN, inAbort=1 at T15 of an encryption: outReady=1 at T16, no outDone. Without the macro, the same stimulus completes with outDone at T42.

Source files
------------

// File: rtl/gift_round_ctrl.sv
// gift_round_ctrl: round sequencer for a one-round-per-cycle GIFT-128 core.
// Drives the state/key-schedule load and update strobes and the 6-bit
// round constant. Encryption runs ROUNDS forward rounds. Decryption first
// winds the key schedule forward to the last round key, then runs ROUNDS
// inverse rounds.
// Optional build macro GIFT_CTRL_ABORT_EN: inAbort returns the sequencer to
// IDLE from LOAD/EXPAND/ROUND. Without the macro inAbort is ignored.
module gift_round_ctrl #(
  parameter int unsigned ROUNDS = 40,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inStart,
  input  logic             inDecrypt,
  input  logic             inAbort,
  output logic             outReady,
  output logic             outBusy,
  output logic             outDone,
  output logic             outStateLoad,
  output logic             outKeyLoad,
  output logic             outKeyFwd,
  output logic             outKeyInv,
  output logic             outRoundEn,
  output logic             outRoundInv,
  output logic [5:0]       outRoundConst,
  output logic [IDX_W-1:0] outRoundIdx
);

  localparam int unsigned RC_W = 6;
  localparam logic [IDX_W-1:0] CNT_FIRST    = IDX_W'(1);
  localparam logic [IDX_W-1:0] CNT_LAST     = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] CNT_EXP_LAST = IDX_W'(ROUNDS - 1);
  localparam logic [RC_W-1:0]  RC_INIT      = RC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_ROUND,
    ST_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [RC_W-1:0]  r_lfsr, w_lfsr_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dec, w_dec_nxt;
  logic             w_abort;

`ifdef GIFT_CTRL_ABORT_EN
  assign w_abort = inAbort;
`else
  logic w_unused_abort;
  assign w_abort        = 1'b0;
  assign w_unused_abort = inAbort;
`endif

  function automatic logic [RC_W-1:0] lfsr_fwd(input logic [RC_W-1:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

  function automatic logic [RC_W-1:0] lfsr_inv(input logic [RC_W-1:0] c);
    return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
  endfunction

  // State, counter, LFSR and mode registers
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state <= ST_IDLE;
      r_lfsr  <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  // Next-state, counter and LFSR sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_dec_nxt   = r_dec;
    case (r_state)
      ST_IDLE: begin
        if (inStart) begin
          w_state_nxt = ST_LOAD;
          w_dec_nxt   = inDecrypt;
        end
      end
      ST_LOAD: begin
        w_lfsr_nxt  = RC_INIT;
        w_cnt_nxt   = CNT_FIRST;
        w_state_nxt = r_dec ? ST_EXPAND : ST_ROUND;
      end
      ST_EXPAND: begin
        w_lfsr_nxt = lfsr_fwd(r_lfsr);
        w_cnt_nxt  = r_cnt + IDX_W'(1);
        if (r_cnt == CNT_EXP_LAST) begin
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (r_dec) begin
          if (r_cnt == CNT_FIRST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt  = r_cnt - IDX_W'(1);
            w_lfsr_nxt = lfsr_inv(r_lfsr);
          end
        end else begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt  = r_cnt + IDX_W'(1);
            w_lfsr_nxt = lfsr_fwd(r_lfsr);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_lfsr_nxt  = '0;
        w_cnt_nxt   = '0;
        w_dec_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_lfsr_nxt  = '0;
        w_cnt_nxt   = '0;
        w_dec_nxt   = 1'b0;
      end
    endcase
    // Abort wins over normal sequencing in the active states
    if (w_abort && (r_state == ST_LOAD || r_state == ST_EXPAND || r_state == ST_ROUND)) begin
      w_state_nxt = ST_IDLE;
      w_lfsr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_dec_nxt   = 1'b0;
    end
  end

  // Output decode from registered state only
  always_comb begin
    outReady      = 1'b0;
    outBusy       = 1'b1;
    outDone       = 1'b0;
    outStateLoad  = 1'b0;
    outKeyLoad    = 1'b0;
    outKeyFwd     = 1'b0;
    outKeyInv     = 1'b0;
    outRoundEn    = 1'b0;
    outRoundInv   = 1'b0;
    outRoundConst = '0;
    outRoundIdx   = '0;
    case (r_state)
      ST_IDLE: begin
        outReady = 1'b1;
        outBusy  = 1'b0;
      end
      ST_LOAD: begin
        outStateLoad = 1'b1;
        outKeyLoad   = 1'b1;
      end
      ST_EXPAND: begin
        outKeyFwd = 1'b1;
      end
      ST_ROUND: begin
        outRoundEn    = 1'b1;
        outRoundConst = r_lfsr;
        outRoundIdx   = r_cnt;
        if (r_dec) begin
          outRoundInv = 1'b1;
          outKeyInv   = (r_cnt != CNT_FIRST);
        end else begin
          outKeyFwd   = (r_cnt != CNT_LAST);
        end
      end
      ST_DONE: begin
        outDone = 1'b1;
      end
      default: begin
        outBusy = 1'b1;
      end
    endcase
  end

endmodule
